cplx_alu: RTL and testbench

- Complex-integer execution unit directly downstream of the register bank.
- Consumes the bank's registered operand ports outA/outB as opA/opB.
- Produces a 64-bit complex result for write-back through the bank's inA/regwe path.
- Operand format: {re[31:0], im[31:0]}, each half signed two's complement. Add/sub/conjugate complete in one cycle; multiply and multiply-accumulate run a shared multiplier over several cycles.

---
 rtl/cplx_pkg.sv | 36 +++
 rtl/cplx_alu_if.sv | 14 +
 rtl/cplx_addsub.sv | 19 +
 rtl/cplx_alu.sv | 168 ++++++++++++++++
 tb/tb_cplx_alu.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cplx_pkg.sv
// Shared types and helpers for the complex-integer ALU: component width, op codes,
// multiply FSM states and {re,im} field accessors.
package cplx_pkg;

  localparam int W = 32;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_MUL    = 3'b010;
  localparam logic [2:0] OP_CONJ   = 3'b011;
  localparam logic [2:0] OP_MAC    = 3'b100;
  localparam logic [2:0] OP_CLRACC = 3'b101;
  localparam logic [2:0] OP_PASS   = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P_AC,
    S_P_BD,
    S_P_AD,
    S_P_BC,
    S_FIN
  } state_t;

  function automatic logic [W-1:0] re_of(input logic [2*W-1:0] v);
    return v[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] im_of(input logic [2*W-1:0] v);
    return v[W-1:0];
  endfunction

  function automatic logic [2*W-1:0] pack(input logic [W-1:0] re, input logic [W-1:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/cplx_alu_if.sv
// Request/result bundle between the register bank side and the complex ALU.
interface cplx_alu_if #(parameter int W = cplx_pkg::W);
  logic           start;
  logic [2:0]     op;
  logic [2*W-1:0] opA;
  logic [2*W-1:0] opB;
  logic [2*W-1:0] result;
  logic           done;
  logic           busy;
  logic           ovf;

  modport master (output start, op, opA, opB, input result, done, busy, ovf);
  modport slave  (input start, op, opA, opB, output result, done, busy, ovf);
endinterface

// File: rtl/cplx_addsub.sv
// Combinational W-bit signed add/subtract with two's-complement overflow flag.
module cplx_addsub
  import cplx_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  logic [W-1:0] w_b;

  // a - b computed as a + ~b + 1, so overflow reduces to the add rule on ~b
  assign w_b   = i_sub ? ~i_b : i_b;
  assign o_sum = i_a + w_b + {{(W-1){1'b0}}, i_sub};
  assign o_ovf = (i_a[W-1] == w_b[W-1]) && (o_sum[W-1] != i_a[W-1]);

endmodule

// File: rtl/cplx_alu.sv
// Complex-integer execution unit: single-cycle ADD/SUB/CONJ/CLRACC/PASS, and
// MUL/MAC sequenced over one shared signed WxW multiplier (done after 5 cycles).
module cplx_alu
  import cplx_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  cplx_alu_if.slave   bus
);

  state_t r_state, w_next;

  logic [W-1:0]          r_a, r_b, r_c, r_d;
  logic                  r_is_mac;
  logic signed [2*W+1:0] r_pr, r_pi;
  logic [2*W-1:0]        r_acc;
  logic [2*W-1:0]        r_result;
  logic                  r_done;
  logic                  r_ovf;

  logic signed [W-1:0]   w_mx, w_my;
  logic signed [2*W-1:0] w_prod;
  logic signed [2*W+1:0] w_prod_ext;
  logic                  w_pr_ovf, w_pi_ovf;

  logic [W-1:0] w_re_a, w_re_b, w_im_a, w_im_b, w_re_sum, w_im_sum;
  logic         w_re_sub, w_im_sub, w_re_ovf, w_im_ovf;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start && (bus.op == OP_MUL || bus.op == OP_MAC)) w_next = S_P_AC;
      S_P_AC:  w_next = S_P_BD;
      S_P_BD:  w_next = S_P_AD;
      S_P_AD:  w_next = S_P_BC;
      S_P_BC:  w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand steering for the one multiplier: ac, bd, ad, bc in successive states
  always_comb begin
    w_mx = r_a;
    w_my = r_c;
    case (r_state)
      S_P_BD: begin w_mx = r_b; w_my = r_d; end
      S_P_AD: begin w_mx = r_a; w_my = r_d; end
      S_P_BC: begin w_mx = r_b; w_my = r_c; end
      default: ;
    endcase
  end

  assign w_prod     = {{W{w_mx[W-1]}}, w_mx} * {{W{w_my[W-1]}}, w_my};
  assign w_prod_ext = {{2{w_prod[2*W-1]}}, w_prod};

  // Representable in W signed bits iff all bits from W-1 upward agree
  assign w_pr_ovf = !((&r_pr[2*W+1:W-1]) || !(|r_pr[2*W+1:W-1]));
  assign w_pi_ovf = !((&r_pi[2*W+1:W-1]) || !(|r_pi[2*W+1:W-1]));

  always_comb begin
    w_re_a   = re_of(bus.opA);
    w_re_b   = re_of(bus.opB);
    w_im_a   = im_of(bus.opA);
    w_im_b   = im_of(bus.opB);
    w_re_sub = 1'b0;
    w_im_sub = 1'b0;
    if (r_state == S_FIN) begin
      w_re_a = re_of(r_acc);
      w_re_b = r_pr[W-1:0];
      w_im_a = im_of(r_acc);
      w_im_b = r_pi[W-1:0];
    end else if (bus.op == OP_SUB) begin
      w_re_sub = 1'b1;
      w_im_sub = 1'b1;
    end else if (bus.op == OP_CONJ) begin
      // re passes through a+0; im is 0-b, which overflows only for the most negative b
      w_re_b   = '0;
      w_im_a   = '0;
      w_im_b   = im_of(bus.opA);
      w_im_sub = 1'b1;
    end
  end

  cplx_addsub u_add_re (
    .i_a(w_re_a), .i_b(w_re_b), .i_sub(w_re_sub), .o_sum(w_re_sum), .o_ovf(w_re_ovf)
  );

  cplx_addsub u_add_im (
    .i_a(w_im_a), .i_b(w_im_b), .i_sub(w_im_sub), .o_sum(w_im_sum), .o_ovf(w_im_ovf)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_is_mac <= 1'b0;
      r_pr     <= '0;
      r_pi     <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_ADD, OP_SUB, OP_CONJ: begin
                r_result <= pack(w_re_sum, w_im_sum);
                r_ovf    <= w_re_ovf | w_im_ovf;
                r_done   <= 1'b1;
              end
              OP_MUL, OP_MAC: begin
                r_a      <= re_of(bus.opA);
                r_b      <= im_of(bus.opA);
                r_c      <= re_of(bus.opB);
                r_d      <= im_of(bus.opB);
                r_is_mac <= (bus.op == OP_MAC);
              end
              OP_CLRACC: begin
                r_acc    <= '0;
                r_result <= '0;
                r_ovf    <= 1'b0;
                r_done   <= 1'b1;
              end
              default: begin
                r_result <= bus.opA;
                r_ovf    <= 1'b0;
                r_done   <= 1'b1;
              end
            endcase
          end
        end
        S_P_AC: r_pr <= w_prod_ext;
        S_P_BD: r_pr <= r_pr - w_prod_ext;
        S_P_AD: r_pi <= w_prod_ext;
        S_P_BC: r_pi <= r_pi + w_prod_ext;
        S_FIN: begin
          r_done <= 1'b1;
          if (r_is_mac) begin
            r_acc    <= pack(w_re_sum, w_im_sum);
            r_result <= pack(w_re_sum, w_im_sum);
            r_ovf    <= w_pr_ovf | w_pi_ovf | w_re_ovf | w_im_ovf;
          end else begin
            r_result <= pack(r_pr[W-1:0], r_pi[W-1:0]);
            r_ovf    <= w_pr_ovf | w_pi_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.done   = r_done;
  assign bus.ovf    = r_ovf;
  assign bus.busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_cplx_alu.sv
// Directed bench for cplx_alu: table of single-cycle vectors plus multi-cycle sequences.
module tb_cplx_alu;
  import cplx_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  int   base;
  bit   ok;

  cplx_alu_if bus();

  cplx_alu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.done) done_cnt++;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name, output bit got);
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s: done seen=0 expected 1 within 12 cycles", name);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
    step();
    bus.start = 1'b0;
  endtask

  // Multi-cycle op: busy after edges T..T+4, done/result after T+5
  task automatic run_mul(input string name, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] res, input logic ovf);
    issue(op, a, b);
    bus.opA = 64'hFFFF_0000_1234_5678;
    bus.opB = 64'h0BAD_F00D_8765_4321;
    for (int k = 0; k < 5; k++) begin
      check({name, "_busy"}, 64'(bus.busy), 64'd1);
      check({name, "_early_done"}, 64'(bus.done), 64'd0);
      step();
    end
    check({name, "_done"}, 64'(bus.done), 64'd1);
    check({name, "_busy_end"}, 64'(bus.busy), 64'd0);
    check({name, "_result"}, bus.result, res);
    check({name, "_ovf"}, 64'(bus.ovf), 64'(ovf));
  endtask

  initial begin
    vecs[0]  = '{"add_basic",  OP_ADD,    64'h00000003_00000004, 64'h00000001_FFFFFFFE, 64'h00000004_00000002, 1'b0};
    vecs[1]  = '{"add_ovf_re", OP_ADD,    64'h7FFFFFFF_00000000, 64'h00000001_00000000, 64'h80000000_00000000, 1'b1};
    vecs[2]  = '{"add_neg_ov", OP_ADD,    64'h80000000_00000001, 64'hFFFFFFFF_00000001, 64'h7FFFFFFF_00000002, 1'b1};
    vecs[3]  = '{"sub_basic",  OP_SUB,    64'h00000005_00000000, 64'h00000007_00000001, 64'hFFFFFFFE_FFFFFFFF, 1'b0};
    vecs[4]  = '{"sub_ovf_re", OP_SUB,    64'h80000000_00000000, 64'h00000001_00000000, 64'h7FFFFFFF_00000000, 1'b1};
    vecs[5]  = '{"sub_ovf_im", OP_SUB,    64'h00000000_7FFFFFFF, 64'h00000000_FFFFFFFF, 64'h00000000_80000000, 1'b1};
    vecs[6]  = '{"conj_basic", OP_CONJ,   64'h00000003_00000004, 64'h11111111_22222222, 64'h00000003_FFFFFFFC, 1'b0};
    vecs[7]  = '{"conj_min",   OP_CONJ,   64'h12345678_80000000, 64'h00000000_00000000, 64'h12345678_80000000, 1'b1};
    vecs[8]  = '{"pass_110",   3'b110,    64'hDEADBEEF_CAFEF00D, 64'h7FFFFFFF_7FFFFFFF, 64'hDEADBEEF_CAFEF00D, 1'b0};
    vecs[9]  = '{"pass_111",   3'b111,    64'h00000001_80000000, 64'h00000000_00000001, 64'h00000001_80000000, 1'b0};
    vecs[10] = '{"clracc",     OP_CLRACC, 64'h55555555_AAAAAAAA, 64'h12345678_12345678, 64'h00000000_00000000, 1'b0};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_ADD;
    bus.opA   = '0;
    bus.opB   = '0;
    step();
    step();
    check("rst_result", bus.result, 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_result"}, bus.result, vecs[i].res);
      check({vecs[i].name, "_ovf"}, 64'(bus.ovf), 64'(vecs[i].ovf));
      check({vecs[i].name, "_done"}, 64'(bus.done), 64'd1);
      check({vecs[i].name, "_busy"}, 64'(bus.busy), 64'd0);
      step();
      check({vecs[i].name, "_done_drop"}, 64'(bus.done), 64'd0);
    end

    run_mul("mul_basic", OP_MUL, 64'h00000003_00000004, 64'h00000001_FFFFFFFE, 64'h0000000B_FFFFFFFE, 1'b0);
    run_mul("mul_neg",   OP_MUL, 64'h00000002_00000003, 64'h00000004_00000005, 64'hFFFFFFF9_00000016, 1'b0);
    run_mul("mul_ovf",   OP_MUL, 64'h40000000_00000000, 64'h00000002_00000000, 64'h80000000_00000000, 1'b1);

    // MAC chain with a start asserted mid-flight that must be ignored
    issue(OP_CLRACC, 64'h0, 64'h0);
    check("mac_clr", bus.result, 64'd0);
    step();
    base = done_cnt;
    issue(OP_MAC, 64'h00000001_00000001, 64'h00000001_00000001);
    bus.opA = '0;
    bus.opB = '0;
    step();
    bus.start = 1'b1;
    bus.op    = OP_MAC;
    bus.opA   = 64'h00000005_00000005;
    bus.opB   = 64'h00000005_00000005;
    step();
    step();
    bus.start = 1'b0;
    wait_done("mac1_wait", ok);
    check("mac1_result", bus.result, 64'h00000000_00000002);
    issue(OP_MAC, 64'h00000001_00000001, 64'h00000001_00000001);
    wait_done("mac2_wait", ok);
    check("mac2_result", bus.result, 64'h00000000_00000004);
    check("mac2_ovf", 64'(bus.ovf), 64'd0);
    for (int k = 0; k < 8; k++) step();
    check("mac_done_count", 64'(done_cnt - base), 64'd2);

    issue(OP_CLRACC, 64'h0, 64'h0);
    step();
    run_mul("mac_acc_a", OP_MAC, 64'h7FFFFFFF_00000000, 64'h00000001_00000000, 64'h7FFFFFFF_00000000, 1'b0);
    run_mul("mac_acc_ov", OP_MAC, 64'h7FFFFFFF_00000000, 64'h00000001_00000000, 64'hFFFFFFFE_00000000, 1'b1);

    // Reset while the FSM sits in P_AD aborts the multiply without a done pulse
    issue(OP_PASS, 64'hDEADBEEF_DEADBEEF, 64'h0);
    issue(OP_MUL, 64'h00000003_00000004, 64'h00000001_FFFFFFFE);
    step();
    step();
    base  = done_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmid_busy", 64'(bus.busy), 64'd0);
    check("rstmid_done", 64'(bus.done), 64'd0);
    check("rstmid_result", bus.result, 64'd0);
    for (int k = 0; k < 6; k++) step();
    check("rstmid_no_done", 64'(done_cnt - base), 64'd0);
    issue(OP_ADD, 64'h00000003_00000004, 64'h00000001_FFFFFFFE);
    check("post_rst_add", bus.result, 64'h00000004_00000002);
    check("post_rst_done", 64'(bus.done), 64'd1);
    step();
    run_mul("post_rst_mac", OP_MAC, 64'h00000001_00000001, 64'h00000001_00000001, 64'h00000000_00000002, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
